// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the basic-gate sweep checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_t;

  localparam int unsigned GATE_AND    = 0;
  localparam int unsigned GATE_OR     = 1;
  localparam int unsigned GATE_NOT    = 2;
  localparam int unsigned GATE_XOR    = 3;
  localparam int unsigned NUM_GATES   = 4;
  localparam int unsigned NUM_VECTORS = 4;

  // Golden outputs of the 2-input gate stage, indexed by the GATE_* constants.
  function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e           = '0;
    e[GATE_AND] = a & b;
    e[GATE_OR]  = a | b;
    e[GATE_NOT] = ~a;
    e[GATE_XOR] = a ^ b;
    return e;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the 2-input gate stage: (a,b) -> expected outputs.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic                 i_a,
  input  logic                 i_b,
  output logic [NUM_GATES-1:0] o_exp_c
);

  // Expected gate outputs for the current vector.
  always_comb begin
    o_exp_c = gate_expected(i_a, i_b);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives the gate stage through all input vectors, compares its outputs
// against the reference model and accumulates pass/fail results.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             xor_in,
  output logic             a_out,
  output logic             b_out,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       mismatch_mask,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SUM_W = ERR_W + 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [1:0]       VEC_LAST = 2'(NUM_VECTORS - 1);

  // A zero settle interval would sample before the vector reaches the gates.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_sweep_checker: SETTLE_CYCLES must be >= 1");
  end

  chk_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_vec, w_vec_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [3:0]       r_mask, w_mask_nxt;
  logic [1:0]       r_ffv, w_ffv_nxt;
  logic             r_ffvalid, w_ffvalid_nxt;

  logic [NUM_GATES-1:0] w_exp;
  logic [NUM_GATES-1:0] w_obs;
  logic [NUM_GATES-1:0] w_mis;
  logic [2:0]           w_pop;
  logic [SUM_W-1:0]     w_sum;
  logic [ERR_W-1:0]     w_err_sat;

  gate_ref_model u_ref (
    .i_a     (r_vec[1]),
    .i_b     (r_vec[0]),
    .o_exp_c (w_exp)
  );

  // Per-gate mismatch; case inequality makes X/Z on an input count as a failure.
  always_comb begin
    w_obs = '0;
    w_obs[GATE_AND] = and_in;
    w_obs[GATE_OR]  = or_in;
    w_obs[GATE_NOT] = not_in;
    w_obs[GATE_XOR] = xor_in;
    w_mis = '0;
    w_pop = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      w_mis[i] = (w_obs[i] !== w_exp[i]);
      w_pop    = w_pop + 3'(w_mis[i]);
    end
  end

  // Saturating add of this vector's mismatch count.
  always_comb begin
    w_sum     = SUM_W'(r_err) + SUM_W'(w_pop);
    w_err_sat = (w_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];
  end

  // Next-state and result update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_vec_nxt     = r_vec;
    w_done_nxt    = 1'b0;
    w_pass_nxt    = r_pass;
    w_err_nxt     = r_err;
    w_mask_nxt    = r_mask;
    w_ffv_nxt     = r_ffv;
    w_ffvalid_nxt = r_ffvalid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_SETTLE;
          w_cnt_nxt     = CNT_LOAD;
          w_vec_nxt     = 2'd0;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = '0;
          w_mask_nxt    = '0;
          w_ffv_nxt     = 2'd0;
          w_ffvalid_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_err_nxt  = w_err_sat;
        w_mask_nxt = r_mask | w_mis;
        if ((w_mis != '0) && !r_ffvalid) begin
          w_ffv_nxt     = r_vec;
          w_ffvalid_nxt = 1'b1;
        end
        if (r_vec == VEC_LAST) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_sat == '0);
        end else begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNT_LOAD;
          w_vec_nxt   = r_vec + 2'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_vec_nxt   = 2'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_vec     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_mask    <= '0;
      r_ffv     <= '0;
      r_ffvalid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vec     <= w_vec_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_err     <= w_err_nxt;
      r_mask    <= w_mask_nxt;
      r_ffv     <= w_ffv_nxt;
      r_ffvalid <= w_ffvalid_nxt;
    end
  end

  assign a_out            = r_vec[1];
  assign b_out            = r_vec[0];
  assign vec_idx          = r_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign mismatch_mask    = r_mask;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-contained sequencer/checker that sits directly around the team's 2-input basic-gate stage (AND, OR, NOT-of-a, XOR).
- On the upstream side it drives the gate inputs a and b through all four combinations.
- On the downstream side it samples the four gate outputs after a settle interval and compares them with an internal reference model.
- It accumulates a saturating error count, a sticky per-gate mismatch mask and the first failing vector, then reports done/pass.
- Replaces hand-timed #delay stimulus with a clocked, reusable sweep.

Parameters:
- SETTLE_CYCLES, 1, cycles held in SETTLE per vector before sampling; must be >=1 (0 is an elaboration error).
- ERR_W, 8, width of err_count.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; accepted only in IDLE.
- and_in  in  1  gate-stage AND output.
- or_in  in  1  gate-stage OR output.
- not_in  in  1  gate-stage NOT(a) output.
- xor_in  in  1  gate-stage XOR output.
- a_out  out  1  gate input a = vec_idx[1].
- b_out  out  1  gate input b = vec_idx[0].
- vec_idx  out  2  current vector index, 0..3.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  err_count==0 at sweep end; held until next accepted start.
- err_count  out  ERR_W  saturating mismatch count.
- mismatch_mask  out  4  sticky per-gate fail bits: [0]AND [1]OR [2]NOT [3]XOR.
- first_fail_vec  out  2  vec_idx of first mismatch.
- first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: vec_idx, a_out, b_out, busy, done, pass, err_count, mismatch_mask, first_fail_vec, first_fail_valid.
  - Reset mid-sweep aborts immediately; no done pulse is produced.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 moves to SETTLE with vec_idx=0 and the settle counter loaded.
  - The same edge clears err_count, mismatch_mask, first_fail_valid, first_fail_vec and pass.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (one cycle):
  - Expected values: exp = {a^b, ~a, a|b, a&b}, with a=vec_idx[1], b=vec_idx[0].
  - m = {xor_in,not_in,or_in,and_in} XOR exp.
  - In simulation, X/Z on any *_in counts as a mismatch for that bit.
  - mismatch_mask |= m.
  - err_count += popcount(m), saturating at 2^ERR_W-1 (no wrap, including partial adds).
  - If m!=0 and first_fail_valid=0: first_fail_vec<=vec_idx and first_fail_valid<=1.
  - If vec_idx==3, go to DONE; otherwise vec_idx++ and return to SETTLE.
- DONE (one cycle):
  - done=1; pass is registered as (final err_count==0).
  - Next state is IDLE; vec_idx returns to 0.
- Latency: done is high in the cycle following edge number 4*(SETTLE_CYCLES+1) counted from the start-accepting edge. For SETTLE_CYCLES=1 that is 8.
- start while busy or in DONE is ignored; there is no queuing.
- A new start in IDLE immediately after DONE is legal (back-to-back sweeps).
- Results stay stable in IDLE until the next accepted start.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum;
  - gate bit-index constants GATE_AND=0, GATE_OR=1, GATE_NOT=2, GATE_XOR=3;
  - NUM_VECTORS=4;
  - function gate_expected(a,b) returning 4 bits.
- One natural sub-module: gate_ref_model, purely combinational, (a,b)->exp[3:0]. It is shared with the future gate-stage bench.
- The FSM, counters and accumulation stay in gate_sweep_checker.

Test Plan:
- Correct gate stage, SETTLE_CYCLES=1, start pulse:
  - a/b sequence 00,01,10,11;
  - done high exactly 8 cycles after start;
  - pass=1, err_count=0, mismatch_mask=0, first_fail_valid=0.
- xor_in stuck 0:
  - mismatches at vectors 1 and 2;
  - err_count=2, mismatch_mask=4'b1000, first_fail_vec=1, pass=0.
- ERR_W=2, all four outputs inverted:
  - err_count saturates at 3 after vector 0 and stays 3;
  - mismatch_mask=4'b1111, first_fail_vec=0.
- start re-pulsed during SETTLE of vector 2:
  - ignored; sweep and done timing unchanged.
  - Second start right after done: results cleared, fresh sweep runs.
- rst_n low for one cycle during SAMPLE of vector 1:
  - all outputs 0 asynchronously;
  - no done pulse;
  - a subsequent start performs a full correct sweep.
- SETTLE_CYCLES=3: done at 16 cycles; a/b each held 4 cycles.
